// File: rtl/config_port_arbiter.sv
// config_port_arbiter: stateful, word-safe arbiter merging NUM_PORTS config write sources into one ConfigFSM stream.
// Define CONFIG_ARB_STATS_EN to build the word_count/dropped_count statistics registers; otherwise they read 0.
module config_port_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            port_active,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_data,
    input  logic [NUM_PORTS-1:0]            port_strobe,
    output logic [DATA_WIDTH-1:0]           ConfigWriteData,
    output logic                            ConfigWriteStrobe,
    output logic                            FSM_Reset,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            timeout_evict,
    output logic [31:0]                     word_count,
    output logic [7:0]                      dropped_count
);
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {DEFAULT, OWN, SWITCH} state_t;

    state_t                   state, state_d;
    logic [IW-1:0]            owner, owner_d, win;
    logic [NUM_PORTS-1:0]     elig, mask, mask_d, grant_d;
    logic [TIMEOUT_WIDTH-1:0] tcnt, tcnt_d;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic                     any, evict, fwd, owner_strobe, dropped;

    // Eligibility, highest-index winner and the granted port's data word
    always_comb begin
        elig     = port_active & ~mask;
        elig[0]  = 1'b0;
        win      = '0;
        sel_data = '0;
        for (int i = 1; i < NUM_PORTS; i++)
            if (elig[i]) win = IW'(i);
        for (int i = 0; i < NUM_PORTS; i++)
            if (grant[i]) sel_data = port_data[i*DATA_WIDTH +: DATA_WIDTH];
        any          = |elig;
        owner_strobe = |(port_strobe & grant);
        dropped      = |(port_strobe & ~grant);
        fwd          = (state != SWITCH) && owner_strobe;
    end

    // Next-state logic; release beats preemption, preemption beats timeout
    always_comb begin
        state_d = state;
        owner_d = owner;
        evict   = 1'b0;
        case (state)
            DEFAULT: begin
                state_d = any ? OWN : DEFAULT;
                owner_d = any ? win : '0;
            end
            OWN: begin
                if (!port_active[owner]) begin
                    state_d = DEFAULT;
                    owner_d = '0;
                end else if (any && win > owner) begin
                    state_d = SWITCH;
                    owner_d = win;
                end else if (tcnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES)) begin
                    state_d = DEFAULT;
                    owner_d = '0;
                    evict   = 1'b1;
                end
            end
            SWITCH: begin
                state_d = any ? OWN : DEFAULT;
                owner_d = any ? win : '0;
            end
            default: begin
                state_d = DEFAULT;
                owner_d = '0;
            end
        endcase
        grant_d   = NUM_PORTS'(1) << owner_d;
        tcnt_d    = (state != OWN || owner_strobe || grant_d != grant) ? '0 : tcnt + TIMEOUT_WIDTH'(1);
        mask_d    = (mask & port_active) | (evict ? grant : '0);
        mask_d[0] = 1'b0;
    end

    // Arbitration state, eviction mask and registered write stream
    always_ff @(posedge CLK) begin
        if (reset) begin
            state             <= DEFAULT;
            owner             <= '0;
            grant             <= NUM_PORTS'(1);
            mask              <= '0;
            tcnt              <= '0;
            ConfigWriteData   <= '0;
            ConfigWriteStrobe <= 1'b0;
            FSM_Reset         <= 1'b0;
            timeout_evict     <= 1'b0;
        end else begin
            state             <= state_d;
            owner             <= owner_d;
            grant             <= grant_d;
            mask              <= mask_d;
            tcnt              <= tcnt_d;
            ConfigWriteStrobe <= fwd;
            if (fwd) ConfigWriteData <= sel_data;
            FSM_Reset         <= grant_d != grant;
            timeout_evict     <= evict;
        end
    end

`ifdef CONFIG_ARB_STATS_EN
    // Forwarded-word counter (wrapping) and dropped-strobe counter (saturating)
    always_ff @(posedge CLK) begin
        if (reset) begin
            word_count    <= '0;
            dropped_count <= '0;
        end else begin
            word_count    <= word_count + 32'(fwd);
            dropped_count <= (dropped && dropped_count != 8'hFF) ? dropped_count + 8'd1 : dropped_count;
        end
    end
`else
    assign word_count    = '0;
    assign dropped_count = '0;
`endif
endmodule

// File: tb/tb_config_port_arbiter.sv
// tb_config_port_arbiter: directed vector table plus timeout, saturation and reset sequences
module tb_config_port_arbiter;
`ifdef CONFIG_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         reset;
    logic [3:0]   port_active, port_strobe, grant;
    logic [127:0] port_data;
    logic [31:0]  ConfigWriteData, word_count;
    logic         ConfigWriteStrobe, FSM_Reset, timeout_evict;
    logic [7:0]   dropped_count;
    int           n_chk = 0;
    int           n_fail = 0;

    config_port_arbiter dut (
        .CLK(CLK), .reset(reset), .port_active(port_active), .port_data(port_data),
        .port_strobe(port_strobe), .ConfigWriteData(ConfigWriteData),
        .ConfigWriteStrobe(ConfigWriteStrobe), .FSM_Reset(FSM_Reset), .grant(grant),
        .timeout_evict(timeout_evict), .word_count(word_count), .dropped_count(dropped_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  a, s;
        logic [31:0] d;
        logic        e_stb;
        logic [31:0] e_data;
        logic [3:0]  e_grant;
        logic        e_fr, e_ev;
        logic [31:0] e_wc;
        logic [7:0]  e_dc;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [31:0] cnt(input logic [31:0] v);
        return STATS ? v : 32'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // port i sees d with its index in the top nibble, so forwarded data identifies its source
    task automatic step(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d);
        port_active = a;
        port_strobe = s;
        port_data   = {d ^ 32'h3000_0000, d ^ 32'h2000_0000, d ^ 32'h1000_0000, d};
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int evicts, fwds, bad;
        tbl[0]  = '{4'b0000, 4'b0001, 32'hA5A5_0001, 1'b1, 32'hA5A5_0001, 4'b0001, 1'b0, 1'b0, 1, 0};
        tbl[1]  = '{4'b0000, 4'b0000, 32'h0,         1'b0, 32'hA5A5_0001, 4'b0001, 1'b0, 1'b0, 1, 0};
        tbl[2]  = '{4'b0100, 4'b0000, 32'h0,         1'b0, 32'hA5A5_0001, 4'b0100, 1'b1, 1'b0, 1, 0};
        tbl[3]  = '{4'b0100, 4'b0100, 32'h11,        1'b1, 32'h2000_0011, 4'b0100, 1'b0, 1'b0, 2, 0};
        tbl[4]  = '{4'b0100, 4'b0100, 32'h22,        1'b1, 32'h2000_0022, 4'b0100, 1'b0, 1'b0, 3, 0};
        tbl[5]  = '{4'b0100, 4'b0100, 32'h33,        1'b1, 32'h2000_0033, 4'b0100, 1'b0, 1'b0, 4, 0};
        tbl[6]  = '{4'b1100, 4'b0100, 32'h44,        1'b1, 32'h2000_0044, 4'b1000, 1'b1, 1'b0, 5, 0};
        tbl[7]  = '{4'b1100, 4'b0100, 32'h55,        1'b0, 32'h2000_0044, 4'b1000, 1'b0, 1'b0, 5, 1};
        tbl[8]  = '{4'b1000, 4'b1000, 32'h66,        1'b1, 32'h3000_0066, 4'b1000, 1'b0, 1'b0, 6, 1};
        tbl[9]  = '{4'b0000, 4'b1000, 32'h77,        1'b1, 32'h3000_0077, 4'b0001, 1'b1, 1'b0, 7, 1};
        tbl[10] = '{4'b0000, 4'b0000, 32'h0,         1'b0, 32'h3000_0077, 4'b0001, 1'b0, 1'b0, 7, 1};
        tbl[11] = '{4'b0000, 4'b0010, 32'h88,        1'b0, 32'h3000_0077, 4'b0001, 1'b0, 1'b0, 7, 2};
        tbl[12] = '{4'b0010, 4'b0001, 32'h99,        1'b1, 32'h0000_0099, 4'b0010, 1'b1, 1'b0, 8, 2};
        tbl[13] = '{4'b0010, 4'b0000, 32'h0,         1'b0, 32'h0000_0099, 4'b0010, 1'b0, 1'b0, 8, 2};

        reset = 1'b1;
        port_active = '0;
        port_strobe = '0;
        port_data = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_stb", ConfigWriteStrobe, 0);
        chk("reset_data", ConfigWriteData, 0);
        chk("reset_grant", grant, 4'b0001);
        chk("reset_fr", FSM_Reset, 0);
        chk("reset_ev", timeout_evict, 0);
        chk("reset_wc", word_count, 0);
        chk("reset_dc", dropped_count, 0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].a, tbl[i].s, tbl[i].d);
            chk($sformatf("v%0d_stb", i), ConfigWriteStrobe, tbl[i].e_stb);
            chk($sformatf("v%0d_data", i), ConfigWriteData, tbl[i].e_data);
            chk($sformatf("v%0d_grant", i), grant, tbl[i].e_grant);
            chk($sformatf("v%0d_fr", i), FSM_Reset, tbl[i].e_fr);
            chk($sformatf("v%0d_ev", i), timeout_evict, tbl[i].e_ev);
            chk($sformatf("v%0d_wc", i), word_count, cnt(tbl[i].e_wc));
            chk($sformatf("v%0d_dc", i), dropped_count, cnt(32'(tbl[i].e_dc)));
        end

        // port 1 idle in OWN: counter hits 255 after 255 idle cycles, eviction on the 256th
        evicts = 0;
        for (int k = 2; k <= 255; k++) begin
            step(4'b0010, 4'b0000, 32'h0);
            if (timeout_evict || grant != 4'b0010) evicts++;
        end
        chk("no_early_evict", evicts, 0);
        step(4'b0010, 4'b0000, 32'h0);
        chk("evict_pulse", timeout_evict, 1);
        chk("evict_grant", grant, 4'b0001);
        chk("evict_fr", FSM_Reset, 1);
        step(4'b0010, 4'b0000, 32'h0);
        chk("evict_one_cycle", timeout_evict, 0);
        step(4'b0010, 4'b0000, 32'h0);
        step(4'b0010, 4'b0000, 32'h0);
        chk("masked_grant", grant, 4'b0001);
        chk("masked_fr", FSM_Reset, 0);
        step(4'b0000, 4'b0000, 32'h0);
        chk("drop_grant", grant, 4'b0001);
        step(4'b0010, 4'b0000, 32'h0);
        chk("regrant", grant, 4'b0010);
        chk("regrant_fr", FSM_Reset, 1);

        // port 3 preempts, then ports 1 and 2 hammer strobes while port 3 owns
        step(4'b1010, 4'b0000, 32'h0);
        chk("pre3_grant", grant, 4'b1000);
        chk("pre3_fr", FSM_Reset, 1);
        step(4'b1000, 4'b0000, 32'h0);
        chk("own3_fr", FSM_Reset, 0);
        chk("own3_stb", ConfigWriteStrobe, 0);
        fwds = 0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step(4'b1000, (i % 128 == 0) ? 4'b1110 : 4'b0110, 32'(i));
            if (ConfigWriteStrobe) begin
                fwds++;
                if (ConfigWriteData[31:28] != 4'h3) bad++;
            end
            if (grant != 4'b1000) bad++;
        end
        chk("sat_fwds", fwds, 3);
        chk("sat_bad", bad, 0);
        chk("sat_dc", dropped_count, cnt(255));
        chk("sat_wc", word_count, cnt(11));

        // reset while port 3 owns with a strobe pending
        reset = 1'b1;
        step(4'b1000, 4'b1000, 32'h123);
        chk("mid_reset_stb", ConfigWriteStrobe, 0);
        chk("mid_reset_grant", grant, 4'b0001);
        chk("mid_reset_data", ConfigWriteData, 0);
        chk("mid_reset_fr", FSM_Reset, 0);
        chk("mid_reset_wc", word_count, 0);
        chk("mid_reset_dc", dropped_count, 0);
        reset = 1'b0;
        step(4'b0000, 4'b0000, 32'h0);
        chk("post_reset_grant", grant, 4'b0001);
        chk("post_reset_stb", ConfigWriteStrobe, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
